// File: rtl/tidc_l2_mem_model_if.sv
// tidc_l2_mem_model_if: TIDC L2 command/response bus between tidc_top (master) and the L2 model (slave).
interface tidc_l2_mem_model_if;
  logic         l2_cmd_valid;
  logic [2:0]   l2_cmd_type;
  logic [63:0]  l2_cmd_addr;
  logic [511:0] l2_cmd_data;
  logic [3:0]   l2_cmd_size;
  logic         l2_cmd_dirty;
  logic         l2_response_valid;
  logic [511:0] l2_response_data;
  logic         l2_response_error;
  modport master(output l2_cmd_valid, l2_cmd_type, l2_cmd_addr, l2_cmd_data, l2_cmd_size, l2_cmd_dirty,
                 input l2_response_valid, l2_response_data, l2_response_error);
  modport slave(input l2_cmd_valid, l2_cmd_type, l2_cmd_addr, l2_cmd_data, l2_cmd_size, l2_cmd_dirty,
                output l2_response_valid, l2_response_data, l2_response_error);
endinterface

// File: rtl/tidc_l2_mem_model.sv
// tidc_l2_mem_model: in-order fixed-latency L2 responder with a line-granular backing store.
module tidc_l2_mem_model #(
  parameter int LATENCY = 4,
  parameter int DEPTH = 4,
  parameter int LINES = 16,
  parameter logic [2:0] CMD_READ = 3'd0,
  parameter logic [2:0] CMD_WRITE = 3'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  tidc_l2_mem_model_if.slave       bus,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   queue_level,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LINES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic [2:0]   typ;
    logic [63:0]  addr;
    logic [511:0] data;
    logic [3:0]   size;
    logic         dirty;
  } cmd_t;
  cmd_t q [DEPTH];
  cmd_t cur;
  logic [511:0] mem [LINES];
  logic [LINES-1:0] vld;
  state_t state;
  logic [7:0] cnt;
  logic [AW-1:0] wp, rp;
  logic full, push, pop, fire, is_rd, is_wr, err;
  logic [LW-1:0] idx;
  assign full = queue_level == (AW+1)'(DEPTH);
  assign push = bus.l2_cmd_valid && !full;
  assign pop = state == IDLE && queue_level != '0;
  assign fire = state == WAIT && cnt == 8'd0;
  assign idx = cur.addr[6 +: LW];
  assign is_rd = cur.typ == CMD_READ;
  assign is_wr = cur.typ == CMD_WRITE;
  assign err = cur.size != 4'd6 || cur.addr[5:0] != 6'd0 || cur.addr >= 64'(LINES * 64) || !(is_rd || is_wr);
  always_ff @(posedge clk) begin
    if (!rst && push) q[wp] <= {bus.l2_cmd_type, bus.l2_cmd_addr, bus.l2_cmd_data, bus.l2_cmd_size, bus.l2_cmd_dirty};
    if (!rst && fire && !err && is_wr && cur.dirty) mem[idx] <= cur.data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      queue_level <= '0;
      overflow <= 1'b0;
      vld <= '0;
      rd_count <= '0;
      wr_count <= '0;
      bus.l2_response_valid <= 1'b0;
      bus.l2_response_data <= '0;
      bus.l2_response_error <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (bus.l2_cmd_valid && full) overflow <= 1'b1;
      queue_level <= queue_level + (AW+1)'(push) - (AW+1)'(pop);
      bus.l2_response_valid <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          cur <= q[rp];
          rp <= rp + 1'b1;
          cnt <= 8'(LATENCY - 2);
          state <= WAIT;
        end
        WAIT: if (fire) begin
          state <= RESP;
          bus.l2_response_valid <= 1'b1;
          bus.l2_response_error <= err;
          bus.l2_response_data <= (err || is_wr) ? '0 : vld[idx] ? mem[idx] : {8{cur.addr}};
          if (!err && is_rd) rd_count <= rd_count + 16'(rd_count != 16'hFFFF);
          if (!err && is_wr) wr_count <= wr_count + 16'(wr_count != 16'hFFFF);
          if (!err && is_wr && cur.dirty) vld[idx] <= 1'b1;
        end else cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tidc_l2_mem_model.sv
// tb_tidc_l2_mem_model: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_tidc_l2_mem_model;
  localparam int LAT = 4;
  localparam int DEPTH = 4;
  localparam int LINES = 16;
  logic clk = 0;
  logic rst = 1;
  logic overflow;
  logic [2:0] queue_level;
  logic [15:0] rd_count, wr_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int peak = 0;
  typedef struct {
    logic [511:0] d;
    logic e;
    int c;
  } exp_t;
  exp_t sb[$];
  tidc_l2_mem_model_if bus();
  tidc_l2_mem_model #(.LATENCY(LAT), .DEPTH(DEPTH), .LINES(LINES)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .overflow(overflow),
    .queue_level(queue_level), .rd_count(rd_count), .wr_count(wr_count));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, b);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && int'(queue_level) > peak) peak = int'(queue_level);
    if (!rst && bus.l2_response_valid) begin
      if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("resp_data", bus.l2_response_data, x.d);
        chk("resp_err", 512'(bus.l2_response_error), 512'(x.e));
        if (x.c >= 0) chk("resp_cycle", 512'(cyc), 512'(x.c));
      end
    end
  end
  task automatic send(input logic [2:0] t, input logic [63:0] a, input logic [511:0] d, input logic [3:0] s,
                      input logic dy, input bit resp, input logic [511:0] ed, input logic ee, input int extra);
    exp_t x;
    bus.l2_cmd_valid = 1;
    bus.l2_cmd_type = t;
    bus.l2_cmd_addr = a;
    bus.l2_cmd_data = d;
    bus.l2_cmd_size = s;
    bus.l2_cmd_dirty = dy;
    x.d = ed;
    x.e = ee;
    x.c = extra < 0 ? -1 : cyc + 1 + LAT + extra;
    if (resp) sb.push_back(x);
    @(negedge clk);
    bus.l2_cmd_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 512'(sb.size()), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic zero_outs(input string n);
    chk({n, "_valid"}, 512'(bus.l2_response_valid), 0);
    chk({n, "_data"}, bus.l2_response_data, 0);
    chk({n, "_err"}, 512'(bus.l2_response_error), 0);
    chk({n, "_ovf"}, 512'(overflow), 0);
    chk({n, "_level"}, 512'(queue_level), 0);
    chk({n, "_rd"}, 512'(rd_count), 0);
    chk({n, "_wr"}, 512'(wr_count), 0);
  endtask
  initial begin
    logic [511:0] d_a5, d_e;
    d_a5 = {64{8'hA5}};
    d_e = {16{32'h1234_5678}};
    bus.l2_cmd_valid = 0;
    bus.l2_cmd_type = 0;
    bus.l2_cmd_addr = 0;
    bus.l2_cmd_data = 0;
    bus.l2_cmd_size = 6;
    bus.l2_cmd_dirty = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    zero_outs("reset");
    send(3'd0, 64'h40, 0, 6, 0, 1, {8{64'h40}}, 0, 0);
    drain();
    chk("rd_after_first", 512'(rd_count), 1);
    send(3'd1, 64'h80, d_a5, 6, 1, 1, 0, 0, 0);
    send(3'd0, 64'h80, 0, 6, 0, 1, d_a5, 0, LAT);
    drain();
    chk("wr_after_dirty", 512'(wr_count), 1);
    chk("rd_after_raw", 512'(rd_count), 2);
    send(3'd1, 64'hC0, {512{1'b1}}, 6, 0, 1, 0, 0, 0);
    send(3'd0, 64'hC0, 0, 6, 0, 1, {8{64'hC0}}, 0, LAT);
    drain();
    chk("wr_after_clean", 512'(wr_count), 2);
    chk("rd_after_clean", 512'(rd_count), 3);
    send(3'd0, 64'h41, 0, 6, 0, 1, 0, 1, -1);
    send(3'd0, 64'(LINES * 64), 0, 6, 0, 1, 0, 1, -1);
    send(3'd0, 64'h40, 0, 5, 0, 1, 0, 1, -1);
    send(3'd3, 64'h40, 0, 6, 0, 1, 0, 1, -1);
    drain();
    chk("rd_after_err", 512'(rd_count), 3);
    chk("wr_after_err", 512'(wr_count), 2);
    chk("ovf_before_burst", 512'(overflow), 0);
    peak = 0;
    send(3'd0, 64'h0, 0, 6, 0, 1, 0, 0, 0);
    send(3'd0, 64'h40, 0, 6, 0, 1, {8{64'h40}}, 0, -1);
    send(3'd0, 64'h80, 0, 6, 0, 1, d_a5, 0, -1);
    send(3'd0, 64'hC0, 0, 6, 0, 1, {8{64'hC0}}, 0, -1);
    send(3'd0, 64'h100, 0, 6, 0, 1, {8{64'h100}}, 0, -1);
    send(3'd0, 64'h140, 0, 6, 0, 0, 0, 0, -1);
    chk("burst_overflow", 512'(overflow), 1);
    drain();
    chk("burst_peak", 512'(peak), DEPTH);
    chk("burst_rd", 512'(rd_count), 8);
    chk("ovf_sticky", 512'(overflow), 1);
    send(3'd1, 64'h100, d_e, 6, 1, 1, 0, 0, 0);
    send(3'd0, 64'h100, 0, 6, 0, 1, d_e, 0, LAT);
    drain();
    send(3'd0, 64'h100, 0, 6, 0, 0, 0, 0, -1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    zero_outs("abort");
    repeat (10) @(negedge clk);
    chk("abort_no_pulse_rd", 512'(rd_count), 0);
    send(3'd0, 64'h100, 0, 6, 0, 1, {8{64'h100}}, 0, 0);
    drain();
    chk("rd_after_abort", 512'(rd_count), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
